vid_wr_burst_sched: RTL

- Read-side sequencer for the 8-in/16-out prefetch FIFO in the video write path.
- Waits until the FIFO holds a full burst, then requests a write slot from the DDR write arbiter with address and length.
- Streams exactly that many 16-bit words from the FIFO to the arbiter using valid/ready.
- Walks line by line through a frame buffer region and pulses frame_done at frame end.

---
 rtl/vid_wr_pkg.sv | 18 +
 rtl/vid_addr_gen.sv | 64 ++++++
 rtl/vid_wr_burst_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vid_wr_pkg.sv
// Shared types and constants for the video write-path burst scheduler.
package vid_wr_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LEN_W  = 8;
  // Beat counts of 1..256 need one bit more than req_len.
  localparam int unsigned CNT_W  = LEN_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    REQ,
    XFER,
    NEXT
  } state_t;

endpackage

// File: rtl/vid_addr_gen.sv
// Frame-buffer walker: tracks column, line and addresses, and sizes each burst
// so that none crosses a line boundary.
module vid_addr_gen #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned LINE_BEATS  = 960,
  parameter int unsigned LINES       = 1080,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned LINE_STRIDE = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [8:0]        cur_len_c,
  output logic              eof_c
);

  import vid_wr_pkg::*;

  localparam int unsigned COL_W  = $clog2(LINE_BEATS + 1);
  localparam int unsigned LINE_W = $clog2(LINES + 1);

  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;
  logic [ADDR_W-1:0] line_base;
  logic [31:0]       rem_c;
  logic              eol_c;

  // Burst size is the smaller of the max burst and what is left of the line.
  always_comb begin
    rem_c     = LINE_BEATS - 32'(col);
    cur_len_c = (rem_c < BURST_LEN) ? CNT_W'(rem_c) : CNT_W'(BURST_LEN);
    eol_c     = (32'(col) + 32'(cur_len_c)) == LINE_BEATS;
    eof_c     = eol_c && (32'(line) == (LINES - 1));
  end

  // Counters load on frame start and step once per completed burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      line      <= '0;
      line_base <= '0;
      addr      <= '0;
    end else if (start) begin
      col       <= '0;
      line      <= '0;
      line_base <= ADDR_W'(BASE_ADDR);
      addr      <= ADDR_W'(BASE_ADDR);
    end else if (advance) begin
      if (eol_c) begin
        col       <= '0;
        line      <= line + LINE_W'(1);
        line_base <= line_base + ADDR_W'(LINE_STRIDE);
        addr      <= line_base + ADDR_W'(LINE_STRIDE);
      end else begin
        col  <= COL_W'(32'(col) + 32'(cur_len_c));
        addr <= addr + ADDR_W'(cur_len_c);
      end
    end
  end

endmodule

// File: rtl/vid_wr_burst_sched.sv
// Read-side sequencer of the video write prefetch FIFO: waits for a full
// burst, requests a DDR write slot and streams the beats with valid/ready.
module vid_wr_burst_sched #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned LVL_W       = 14,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned LINE_BEATS  = 960,
  parameter int unsigned LINES       = 1080,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned LINE_STRIDE = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              abort,
  input  logic [LVL_W-1:0]  fifo_rd_level,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic              req,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_len,
  input  logic              req_gnt,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  output logic              busy,
  output logic              frame_done,
  output logic              err_underrun
);

  import vid_wr_pkg::*;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bc_q, bc_d;
  logic              abort_pend_q;
  logic              abort_c;
  logic              beat_c;
  logic              in_xfer_c;
  logic              load_c;
  logic              advance_c;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cur_len_c;
  logic              eof_c;

  vid_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .LINE_BEATS  (LINE_BEATS),
    .LINES       (LINES),
    .BASE_ADDR   (BASE_ADDR),
    .LINE_STRIDE (LINE_STRIDE)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (load_c),
    .advance   (advance_c),
    .addr      (addr),
    .cur_len_c (cur_len_c),
    .eof_c     (eof_c)
  );

  // Next-state logic plus the zero-latency FIFO-to-arbiter beat path.
  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    load_c     = 1'b0;
    advance_c  = 1'b0;
    in_xfer_c  = (state_q == XFER);
    abort_c    = abort_pend_q | abort;
    beat_c     = in_xfer_c && fifo_rd_vld && wready;
    fifo_rd_en = in_xfer_c && wready;
    wvalid     = in_xfer_c && fifo_rd_vld;
    wdata      = in_xfer_c ? fifo_rd_data : '0;
    wlast      = in_xfer_c && (bc_q == CNT_W'(1));

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          load_c  = 1'b1;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (abort_c) begin
          state_d = IDLE;
        end else if (32'(fifo_rd_level) >= 32'(cur_len_c)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        // Abort waits here: a pending request is always carried through.
        if (req_gnt && req) begin
          bc_d    = cur_len_c;
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat_c) begin
          bc_d = bc_q - CNT_W'(1);
          if (bc_q == CNT_W'(1)) begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        advance_c = 1'b1;
        if (eof_c || abort_c) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, beat counter and abort latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bc_q         <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      if ((state_q == IDLE) || (state_d == IDLE)) begin
        abort_pend_q <= 1'b0;
      end else if (abort) begin
        abort_pend_q <= 1'b1;
      end
    end
  end

  // Registered request, status and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req          <= 1'b0;
      req_addr     <= '0;
      req_len      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      req        <= (state_d == REQ);
      busy       <= (state_d != IDLE);
      // High during the NEXT cycle that closes the final burst of the frame.
      frame_done <= in_xfer_c && (state_d == NEXT) && eof_c;
      if ((state_q == WAIT_DATA) && (state_d == REQ)) begin
        req_addr <= addr;
        req_len  <= LEN_W'(cur_len_c - CNT_W'(1));
      end
      if (in_xfer_c && wready && !fifo_rd_vld) begin
        err_underrun <= 1'b1;
      end
    end
  end

endmodule
